sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 93 +++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM with a registered read port.
// Port 0 is the lookup requester, port 1 the refill requester. Port 1 can lock the
// SRAM for a burst; otherwise simultaneous requests alternate round-robin.
module sram_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  input  logic                    req_lock_i,
  output logic [1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    sram_we_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  lock_state_e lock_q, lock_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [1:0]  grant;

  // Grant selection: lock forces port 1, contention resolved by the pointer.
  always_comb begin
    grant = '0;
    if (lock_q == LOCK_HELD) begin
      grant[1] = req_valid_i[1];
    end else if (&req_valid_i) begin
      grant[ptr_q] = 1'b1;
    end else begin
      grant = req_valid_i;
    end
    req_ready_o = grant;
  end

  // SRAM command mux: granted port drives the SRAM, otherwise all zeros.
  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (grant[0]) begin
      sram_we_o    = req_we_i[0];
      sram_addr_o  = req_addr_i[0 +: ADDR_WIDTH];
      sram_wdata_o = req_wdata_i[0 +: DATA_WIDTH];
    end else if (grant[1]) begin
      sram_we_o    = req_we_i[1];
      sram_addr_o  = req_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
      sram_wdata_o = req_wdata_i[DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next state: pointer moves away from the winner, lock follows port-1 grants.
  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    rsp_valid_d = grant & ~req_we_i;
    if (grant[0]) begin
      ptr_d = 1'b1;
    end
    if (grant[1]) begin
      ptr_d  = 1'b0;
      lock_d = req_lock_i ? LOCK_HELD : LOCK_IDLE;
    end
  end

  // State registers; reset also drops any response in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= 1'b0;
      lock_q      <= LOCK_IDLE;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed stimulus pushes expected read
// responses (port, data, cycle); a forked monitor pops them when rsp_valid_o fires.
module tb_sram_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] W0 = 64'h0000_0000_0000_0123;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic            req_lock;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  int              cyc_cnt;
  int              checks;
  int              errors;
  int              rsp_cnt [2];

  typedef struct {
    logic [1:0]    vec;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  sram_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_lock_i  (req_lock),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // SRAM model: write commits at the edge, read data registered.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  function automatic logic [DW-1:0] memv(input int unsigned a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin
        if (rsp_valid[0] === 1'b1) rsp_cnt[0]++;
        if (rsp_valid[1] === 1'b1) rsp_cnt[1]++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got valid=%b expected none (cycle %0d)", rsp_valid, cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(e.vec));
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_cycle", 64'(cyc_cnt), 64'(e.cyc));
        end
      end
    end
  endtask

  // One cycle: drive inputs, check combinational outputs mid-cycle, queue any read response.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic lk,
                      input logic [1:0] exp_rdy, input logic exp_we,
                      input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wd,
                      input logic push, input logic [DW-1:0] exp_rd);
    exp_t e;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, W0};
    req_lock  = lk;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("sram_we", 64'(sram_we), 64'(exp_we));
    chk("sram_addr", 64'(sram_addr), 64'(exp_addr));
    chk("sram_wdata", sram_wdata, exp_wd);
    if (push) begin
      e.vec  = exp_rdy;
      e.data = exp_rd;
      e.cyc  = cyc_cnt + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_lock  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = memv(i);
    cyc_cnt    = 0;
    checks     = 0;
    errors     = 0;
    rsp_cnt[0] = 0;
    rsp_cnt[1] = 0;
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    req_lock   = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_sram_we", 64'(sram_we), 64'h0);
    chk("reset_sram_addr", 64'(sram_addr), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both read at once: port 0 first, then port 1 on pointer, port 0 alone
    step(2'b11, 2'b00, 10'h010, 10'h020, '0, 1'b0, 2'b01, 1'b0, 10'h010, W0, 1'b1, 64'hA5A5_0000_0000_0010);
    step(2'b11, 2'b00, 10'h011, 10'h020, '0, 1'b0, 2'b10, 1'b0, 10'h020, '0, 1'b1, 64'hA5A5_0000_0000_0020);
    step(2'b01, 2'b00, 10'h011, 10'h000, '0, 1'b0, 2'b01, 1'b0, 10'h011, W0, 1'b1, 64'hA5A5_0000_0000_0011);

    // Write then read-back the top address on port 1
    step(2'b10, 2'b10, 10'h000, 10'h3FF, 64'hDEAD_BEEF, 1'b0, 2'b10, 1'b1, 10'h3FF, 64'hDEAD_BEEF, 1'b0, '0);
    step(2'b10, 2'b00, 10'h000, 10'h3FF, '0, 1'b0, 2'b10, 1'b0, 10'h3FF, '0, 1'b1, 64'h0000_0000_DEAD_BEEF);

    // Port 0 alone so the pointer favours port 1 before the burst
    step(2'b01, 2'b00, 10'h005, 10'h000, '0, 1'b0, 2'b01, 1'b0, 10'h005, W0, 1'b1, 64'hA5A5_0000_0000_0005);

    // Locked 4-write burst with port 0 waiting
    step(2'b11, 2'b10, 10'h005, 10'h100, 64'h1000, 1'b1, 2'b10, 1'b1, 10'h100, 64'h1000, 1'b0, '0);
    step(2'b11, 2'b10, 10'h005, 10'h101, 64'h1001, 1'b1, 2'b10, 1'b1, 10'h101, 64'h1001, 1'b0, '0);
    step(2'b11, 2'b10, 10'h005, 10'h102, 64'h1002, 1'b1, 2'b10, 1'b1, 10'h102, 64'h1002, 1'b0, '0);
    step(2'b11, 2'b10, 10'h005, 10'h103, 64'h1003, 1'b0, 2'b10, 1'b1, 10'h103, 64'h1003, 1'b0, '0);
    step(2'b11, 2'b00, 10'h005, 10'h100, '0, 1'b0, 2'b01, 1'b0, 10'h005, W0, 1'b1, 64'hA5A5_0000_0000_0005);
    step(2'b10, 2'b00, 10'h000, 10'h100, '0, 1'b0, 2'b10, 1'b0, 10'h100, '0, 1'b1, 64'h0000_0000_0000_1000);
    step(2'b10, 2'b00, 10'h000, 10'h103, '0, 1'b0, 2'b10, 1'b0, 10'h103, '0, 1'b1, 64'h0000_0000_0000_1003);
    idle();
    idle();

    // Continuous contention: grants alternate, four responses each
    r0 = rsp_cnt[0];
    r1 = rsp_cnt[1];
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a0, a1;
      a0 = AW'(10'h060 + i / 2);
      a1 = AW'(10'h070 + i / 2);
      if (i % 2 == 0)
        step(2'b11, 2'b00, a0, a1, '0, 1'b0, 2'b01, 1'b0, a0, W0, 1'b1, memv(a0));
      else
        step(2'b11, 2'b00, a0, a1, '0, 1'b0, 2'b10, 1'b0, a1, '0, 1'b1, memv(a1));
    end
    idle();
    idle();
    chk("rr_rsp_count_p0", 64'(rsp_cnt[0] - r0), 64'd4);
    chk("rr_rsp_count_p1", 64'(rsp_cnt[1] - r1), 64'd4);

    // Reset right after a port-0 read grant: response dropped, pointer back to 0
    step(2'b01, 2'b00, 10'h040, 10'h000, '0, 1'b0, 2'b01, 1'b0, 10'h040, W0, 1'b0, '0);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("rst_drop_rsp", 64'(rsp_valid), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_rsp", 64'(rsp_valid), 64'h0);
    rst_n = 1'b1;
    step(2'b11, 2'b00, 10'h041, 10'h042, '0, 1'b0, 2'b01, 1'b0, 10'h041, W0, 1'b1, 64'hA5A5_0000_0000_0041);
    step(2'b10, 2'b00, 10'h000, 10'h042, '0, 1'b0, 2'b10, 1'b0, 10'h042, '0, 1'b1, 64'hA5A5_0000_0000_0042);

    // Reset while locked: lock cleared
    step(2'b10, 2'b10, 10'h000, 10'h043, 64'h4343, 1'b1, 2'b10, 1'b1, 10'h043, 64'h4343, 1'b0, '0);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b11, 2'b00, 10'h044, 10'h045, '0, 1'b0, 2'b01, 1'b0, 10'h044, W0, 1'b1, 64'hA5A5_0000_0000_0044);
    step(2'b10, 2'b00, 10'h000, 10'h045, '0, 1'b0, 2'b10, 1'b0, 10'h045, '0, 1'b1, 64'hA5A5_0000_0000_0045);

    // Lock held while port 1 idles: nothing granted, SRAM idle, lock kept
    step(2'b10, 2'b10, 10'h000, 10'h200, 64'h2000, 1'b1, 2'b10, 1'b1, 10'h200, 64'h2000, 1'b0, '0);
    for (int i = 0; i < 3; i++)
      step(2'b01, 2'b00, 10'h055, 10'h000, '0, 1'b0, 2'b00, 1'b0, 10'h000, '0, 1'b0, '0);
    step(2'b11, 2'b10, 10'h055, 10'h201, 64'h2001, 1'b0, 2'b10, 1'b1, 10'h201, 64'h2001, 1'b0, '0);
    step(2'b01, 2'b00, 10'h055, 10'h000, '0, 1'b0, 2'b01, 1'b0, 10'h055, W0, 1'b1, 64'hA5A5_0000_0000_0055);
    idle();
    idle();
    idle();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
